pc_gen: RTL and testbench
=========================

Name: pc_gen

Overview:
- Parametrised program-counter generator for the RV32I fetch stage. It computes the sequential next PC internally and arbitrates among NUM_REDIR prioritised redirect sources (trap, branch flush, predictor).
- It presents a fetch address with a valid/ready handshake and halts with a sticky fault on a misaligned redirect target.
- It sits between the hazard unit/EX-stage redirect logic and the instruction memory port.

Parameters:
- XLEN, 32, address width in bits.
- RESET_VEC, 32'h0000_0000, PC loaded on reset. Must be INC-aligned.
- NUM_REDIR, 3, number of redirect channels. Index 0 has the highest priority. Legal range 1..8.
- INC, 4, sequential increment in bytes. Alignment check uses log2(INC) LSBs.
- CNT_W, 16, width of the redirect event counter.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset.
- pc_write  in  1  stall control. 0 holds the sequential advance.
- redir_valid  in  NUM_REDIR  per-channel redirect request.
- redir_addr  in  NUM_REDIR*XLEN  packed targets. Channel i occupies bits [i*XLEN +: XLEN].
- fetch_ready  in  1  instruction memory accepts pc_current this cycle.
- pc_current  out  XLEN  current fetch address.
- fetch_valid  out  1  pc_current is a valid fetch request.
- redir_id  out  $clog2(NUM_REDIR) (min 1)  index of the last redirect taken.
- misalign_err  out  1  sticky fault flag.
- fault_addr  out  XLEN  offending target captured on fault.
- redir_count  out  CNT_W  saturating count of redirects taken.

Behaviour:
- Reset: rst_n is synchronous, active-low, sampled on the rising edge of clk. When rst_n=0:
  - pc_current=RESET_VEC, fetch_valid=0, redir_id=0, misalign_err=0, fault_addr=0, redir_count=0.
  - FSM goes to BOOT.
  - Reset mid-operation discards any in-flight state within the same edge.
- FSM states: BOOT, RUN, HALT.
- BOOT:
  - fetch_valid=0 for exactly one cycle after reset release.
  - Next state is RUN with pc_current unchanged, unless a redirect is present; that redirect is processed per the redirect rules below.
- RUN:
  - fetch_valid=1.
  - Sequential advance occurs iff no redirect and pc_write=1 and fetch_ready=1. Then pc_current <= pc_current + INC, wrapping modulo 2^XLEN (e.g. 32'hFFFF_FFFC -> 32'h0000_0000). No flag is raised on wrap.
  - pc_write=0 or fetch_ready=0 with no redirect: pc_current holds.
- Redirect select:
  - Pick the lowest index i with redir_valid[i]=1.
  - Redirects override pc_write and fetch_ready; flush beats stall. Valid in BOOT and RUN.
- Aligned target (redir_addr[i] low log2(INC) bits == 0):
  - pc_current <= target.
  - redir_id <= i.
  - redir_count increments, saturating at all-ones.
  - Next state is RUN; fetch_valid=1 the following cycle.
- Misaligned target:
  - pc_current holds.
  - misalign_err <= 1, fault_addr <= target, redir_id <= i.
  - redir_count is not incremented.
  - Next state is HALT.
- HALT:
  - fetch_valid=0. pc_current, fault_addr, and misalign_err hold.
  - All redirects and pc_write are ignored. Exit is by reset only.
- Lower-priority redirects in the same cycle are dropped silently. Their alignment is not checked.
- Latency: a redirect asserted in cycle N appears on pc_current in cycle N+1. There is no combinational path from inputs to outputs.
- All outputs are registered.

Test Plan:
- Reset release with RESET_VEC=32'h0000_1000, pc_write=1, fetch_ready=1 -> cycle 1: fetch_valid=0, pc=0x1000. Then pc=0x1000, 0x1004, 0x1008 on successive cycles with fetch_valid=1.
- Stall and backpressure: toggle pc_write=0 for 2 cycles, then fetch_ready=0 for 2 cycles, from pc=0x20 -> pc holds at 0x20 for 4 cycles, then resumes 0x24.
- Simultaneous redirects: redir_valid=3'b110 with ch1=0x400 and ch2=0x800, together with pc_write=0 -> next cycle pc=0x400, redir_id=1, redir_count=1. Then redir_valid=3'b111 with ch0=0x100 -> pc=0x100, redir_id=0, redir_count=2.
- Misalign: ch2=0x0000_0102 in RUN -> next cycle misalign_err=1, fault_addr=0x102, fetch_valid=0, pc unchanged, redir_count unchanged. A subsequent ch0 redirect to 0x200 -> no change. rst_n=0 -> all outputs return to their reset values.
- Wrap and saturation: pc=32'hFFFF_FFFC with an advance -> pc=0. With CNT_W=2, issue 5 aligned redirects -> redir_count=3.
- Redirect in BOOT: ch0=0x80 asserted in the first cycle after reset release -> next cycle pc=0x80, fetch_valid=1, redir_count=1.

Source files
------------

// File: rtl/pc_gen_if.sv
// rtl/pc_gen_if.sv - fetch/redirect bundle between pc_gen and its neighbours
interface pc_gen_if #(
    parameter int XLEN      = 32,
    parameter int NUM_REDIR = 3,
    parameter int CNT_W     = 16
);
    localparam int ID_W = (NUM_REDIR > 1) ? $clog2(NUM_REDIR) : 1;

    logic                      pc_write;
    logic [NUM_REDIR-1:0]      redir_valid;
    logic [NUM_REDIR*XLEN-1:0] redir_addr;
    logic                      fetch_ready;
    logic [XLEN-1:0]           pc_current;
    logic                      fetch_valid;
    logic [ID_W-1:0]           redir_id;
    logic                      misalign_err;
    logic [XLEN-1:0]           fault_addr;
    logic [CNT_W-1:0]          redir_count;

    modport master (
        input  pc_write, redir_valid, redir_addr, fetch_ready,
        output pc_current, fetch_valid, redir_id, misalign_err, fault_addr, redir_count
    );

    modport slave (
        output pc_write, redir_valid, redir_addr, fetch_ready,
        input  pc_current, fetch_valid, redir_id, misalign_err, fault_addr, redir_count
    );
endinterface

// File: rtl/pc_gen.sv
// rtl/pc_gen.sv - RV32I fetch PC generator with prioritised redirects and misalign halt
module pc_gen #(
    parameter int              XLEN      = 32,
    parameter logic [XLEN-1:0] RESET_VEC = 32'h0000_0000,
    parameter int              NUM_REDIR = 3,
    parameter int              INC       = 4,
    parameter int              CNT_W     = 16
) (
    input  logic     clk,
    input  logic     rst_n,
    pc_gen_if.master bus
);
    localparam int              ID_W       = (NUM_REDIR > 1) ? $clog2(NUM_REDIR) : 1;
    localparam logic [XLEN-1:0] ALIGN_MASK = XLEN'(INC - 1);

    typedef enum logic [1:0] {BOOT, RUN, HALT} state_t;

    state_t           state_q, state_d;
    logic [XLEN-1:0]  pc_q, pc_d;
    logic [XLEN-1:0]  fault_q, fault_d;
    logic [ID_W-1:0]  id_q, id_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;
    logic             fv_q, fv_d;

    logic             redir_any;
    logic [ID_W-1:0]  sel_id;
    logic [XLEN-1:0]  sel_addr;
    logic             sel_misaligned;

    // Scan from the lowest priority upward so the lowest set index wins.
    always_comb begin
        redir_any = 1'b0;
        sel_id    = '0;
        sel_addr  = '0;
        for (int i = NUM_REDIR - 1; i >= 0; i--) begin
            if (bus.redir_valid[i]) begin
                redir_any = 1'b1;
                sel_id    = ID_W'(i);
                sel_addr  = bus.redir_addr[i*XLEN +: XLEN];
            end
        end
        sel_misaligned = |(sel_addr & ALIGN_MASK);
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        fault_d = fault_q;
        id_d    = id_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        case (state_q)
            BOOT, RUN: begin
                if (redir_any) begin
                    id_d = sel_id;
                    if (sel_misaligned) begin
                        err_d   = 1'b1;
                        fault_d = sel_addr;
                        state_d = HALT;
                    end else begin
                        pc_d    = sel_addr;
                        state_d = RUN;
                        if (cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
                    end
                end else if (state_q == RUN) begin
                    if (bus.pc_write && bus.fetch_ready) pc_d = pc_q + XLEN'(INC);
                end else begin
                    state_d = RUN;
                end
            end
            HALT:    state_d = HALT;
            default: state_d = BOOT;
        endcase
        fv_d = (state_d == RUN);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= BOOT;
            pc_q    <= RESET_VEC;
            fault_q <= '0;
            id_q    <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            fv_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            fault_q <= fault_d;
            id_q    <= id_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            fv_q    <= fv_d;
        end
    end

    assign bus.pc_current   = pc_q;
    assign bus.fetch_valid  = fv_q;
    assign bus.redir_id     = id_q;
    assign bus.misalign_err = err_q;
    assign bus.fault_addr   = fault_q;
    assign bus.redir_count  = cnt_q;
endmodule

// File: tb/tb_pc_gen.sv
// tb/tb_pc_gen.sv - scoreboard bench for pc_gen with directed vectors
module tb_pc_gen;
    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    pc_gen_if #(.XLEN(32), .NUM_REDIR(3), .CNT_W(2)) bus ();

    pc_gen #(
        .XLEN(32), .RESET_VEC(32'h0000_1000), .NUM_REDIR(3), .INC(4), .CNT_W(2)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    typedef struct {
        int          vec;
        logic [31:0] pc;
        logic        fv;
        logic [1:0]  id;
        logic        err;
        logic [31:0] fault;
        logic [1:0]  cnt;
    } exp_t;

    exp_t exp_q[$];
    int   n_chk  = 0;
    int   n_fail = 0;
    int   vec_no = 0;

    task automatic chk(input string name, input int vec, input logic [31:0] act, input logic [31:0] want);
        n_chk++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s vec%0d: got %h expected %h", name, vec, act, want);
        end
    endtask

    // Drive one cycle of inputs away from the active edge and queue the outputs expected after it.
    task automatic cyc(input logic rn, input logic pw, input logic fr, input logic [2:0] rv,
                       input logic [31:0] a0, input logic [31:0] a1, input logic [31:0] a2,
                       input logic [31:0] e_pc, input logic e_fv, input logic [1:0] e_id,
                       input logic e_err, input logic [31:0] e_fault, input logic [1:0] e_cnt);
        exp_t e;
        @(negedge clk);
        rst_n           = rn;
        bus.pc_write    = pw;
        bus.fetch_ready = fr;
        bus.redir_valid = rv;
        bus.redir_addr  = {a2, a1, a0};
        e.vec = vec_no; e.pc = e_pc; e.fv = e_fv; e.id = e_id;
        e.err = e_err; e.fault = e_fault; e.cnt = e_cnt;
        exp_q.push_back(e);
        vec_no++;
    endtask

    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("pc_current",   e.vec, bus.pc_current,          e.pc);
                chk("fetch_valid",  e.vec, 32'(bus.fetch_valid),    32'(e.fv));
                chk("redir_id",     e.vec, 32'(bus.redir_id),       32'(e.id));
                chk("misalign_err", e.vec, 32'(bus.misalign_err),   32'(e.err));
                chk("fault_addr",   e.vec, bus.fault_addr,          e.fault);
                chk("redir_count",  e.vec, 32'(bus.redir_count),    32'(e.cnt));
            end
        end
    end

    initial begin
        rst_n = 1'b0;
        bus.pc_write = 1'b0; bus.fetch_ready = 1'b0;
        bus.redir_valid = '0; bus.redir_addr = '0;
        //   rn pw fr rv      a0            a1            a2            pc            fv id err fault         cnt
        cyc(0, 1, 1, 3'b000, 32'h0,        32'h0,        32'h0,        32'h0000_1000, 0, 0, 0, 32'h0,       0);
        cyc(0, 1, 1, 3'b000, 32'h0,        32'h0,        32'h0,        32'h0000_1000, 0, 0, 0, 32'h0,       0);
        cyc(1, 1, 1, 3'b000, 32'h0,        32'h0,        32'h0,        32'h0000_1000, 1, 0, 0, 32'h0,       0);
        cyc(1, 1, 1, 3'b000, 32'h0,        32'h0,        32'h0,        32'h0000_1004, 1, 0, 0, 32'h0,       0);
        cyc(1, 1, 1, 3'b000, 32'h0,        32'h0,        32'h0,        32'h0000_1008, 1, 0, 0, 32'h0,       0);
        // stall and backpressure from 0x20
        cyc(1, 1, 1, 3'b001, 32'h20,       32'h0,        32'h0,        32'h0000_0020, 1, 0, 0, 32'h0,       1);
        cyc(1, 0, 1, 3'b000, 32'h0,        32'h0,        32'h0,        32'h0000_0020, 1, 0, 0, 32'h0,       1);
        cyc(1, 0, 1, 3'b000, 32'h0,        32'h0,        32'h0,        32'h0000_0020, 1, 0, 0, 32'h0,       1);
        cyc(1, 1, 0, 3'b000, 32'h0,        32'h0,        32'h0,        32'h0000_0020, 1, 0, 0, 32'h0,       1);
        cyc(1, 1, 0, 3'b000, 32'h0,        32'h0,        32'h0,        32'h0000_0020, 1, 0, 0, 32'h0,       1);
        cyc(1, 1, 1, 3'b000, 32'h0,        32'h0,        32'h0,        32'h0000_0024, 1, 0, 0, 32'h0,       1);
        // simultaneous redirects, flush beats stall, counter saturates at 3
        cyc(1, 0, 1, 3'b110, 32'h0,        32'h400,      32'h800,      32'h0000_0400, 1, 1, 0, 32'h0,       2);
        cyc(1, 1, 1, 3'b111, 32'h100,      32'h400,      32'h800,      32'h0000_0100, 1, 0, 0, 32'h0,       3);
        cyc(1, 1, 0, 3'b100, 32'h0,        32'h0,        32'h300,      32'h0000_0300, 1, 2, 0, 32'h0,       3);
        cyc(1, 1, 1, 3'b010, 32'h0,        32'h500,      32'h0,        32'h0000_0500, 1, 1, 0, 32'h0,       3);
        // misaligned lower-priority target is dropped unchecked
        cyc(1, 1, 1, 3'b011, 32'h600,      32'h602,      32'h0,        32'h0000_0600, 1, 0, 0, 32'h0,       3);
        // wrap at top of address space
        cyc(1, 1, 1, 3'b001, 32'hFFFF_FFFC, 32'h0,       32'h0,        32'hFFFF_FFFC, 1, 0, 0, 32'h0,       3);
        cyc(1, 1, 1, 3'b000, 32'h0,        32'h0,        32'h0,        32'h0000_0000, 1, 0, 0, 32'h0,       3);
        cyc(1, 1, 1, 3'b000, 32'h0,        32'h0,        32'h0,        32'h0000_0004, 1, 0, 0, 32'h0,       3);
        // misalign halt, then everything ignored
        cyc(1, 1, 1, 3'b100, 32'h0,        32'h0,        32'h102,      32'h0000_0004, 0, 2, 1, 32'h102,     3);
        cyc(1, 1, 1, 3'b001, 32'h200,      32'h0,        32'h0,        32'h0000_0004, 0, 2, 1, 32'h102,     3);
        cyc(1, 1, 1, 3'b000, 32'h0,        32'h0,        32'h0,        32'h0000_0004, 0, 2, 1, 32'h102,     3);
        cyc(0, 1, 1, 3'b001, 32'h200,      32'h0,        32'h0,        32'h0000_1000, 0, 0, 0, 32'h0,       0);
        // redirect taken straight out of BOOT
        cyc(1, 1, 1, 3'b001, 32'h80,       32'h0,        32'h0,        32'h0000_0080, 1, 0, 0, 32'h0,       1);
        cyc(1, 1, 1, 3'b000, 32'h0,        32'h0,        32'h0,        32'h0000_0084, 1, 0, 0, 32'h0,       1);
        cyc(1, 0, 0, 3'b010, 32'h0,        32'h86,       32'h0,        32'h0000_0084, 0, 1, 1, 32'h86,      1);
        cyc(1, 1, 1, 3'b101, 32'h200,      32'h0,        32'h300,      32'h0000_0084, 0, 1, 1, 32'h86,      1);
        cyc(0, 0, 0, 3'b000, 32'h0,        32'h0,        32'h0,        32'h0000_1000, 0, 0, 0, 32'h0,       0);
        // BOOT leaves to RUN regardless of stall inputs
        cyc(1, 0, 0, 3'b000, 32'h0,        32'h0,        32'h0,        32'h0000_1000, 1, 0, 0, 32'h0,       0);
        cyc(1, 1, 1, 3'b000, 32'h0,        32'h0,        32'h0,        32'h0000_1004, 1, 0, 0, 32'h0,       0);

        for (int k = 0; k < 10 && exp_q.size() != 0; k++) @(posedge clk);
        #2;
        n_chk++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
